// File: rtl/spider_pkg.sv
// Shared types and constants for the falling-block lane engine.
package spider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } run_state_t;

    // Galois LFSR x^16+x^14+x^13+x^11+1, shifting right
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int HIT_Y_DEF      = 415;
    localparam int LOSE_Y_DEF     = 515;
    localparam int SPAWN_MIN_DEF  = -300;
    localparam int SPAWN_SPAN_DEF = 235;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/spider_lane.sv
// One lane: falling y register, button edge detect, hit flash timer and
// spawn position derived from the shared LFSR byte.
module spider_lane
    import spider_pkg::*;
#(
    parameter int IDX        = 0,
    parameter int Y_W        = 13,
    parameter int HIT_Y      = HIT_Y_DEF,
    parameter int LOSE_Y     = LOSE_Y_DEF,
    parameter int SPAWN_MIN  = SPAWN_MIN_DEF,
    parameter int SPAWN_SPAN = SPAWN_SPAN_DEF,
    parameter int FLASH_CYC  = 12000000
) (
    input  logic                  clk_vga,
    input  logic                  game_rst_n,
    input  logic                  btn,
    input  logic [7:0]            lfsr_lo,
    input  logic                  tick,
    input  logic                  run,
    input  logic                  freeze,
    input  logic                  load,
    input  logic                  clear,
    output logic signed [Y_W-1:0] ytop,
    output logic                  flash,
    output logic                  hit,
    output logic                  miss,
    output logic                  lost
);

    localparam int FT_W = $clog2(FLASH_CYC + 1);
    localparam logic signed [Y_W-1:0] HIT_V   = Y_W'(HIT_Y);
    localparam logic signed [Y_W-1:0] LOSE_V  = Y_W'(LOSE_Y);
    localparam logic signed [Y_W-1:0] SPAWN_V = Y_W'(SPAWN_MIN);

    logic                  btn_q;
    logic                  press;
    logic                  at_hit;
    logic                  move;
    logic [9:0]            sum;
    logic [8:0]            offset;
    logic signed [Y_W-1:0] spawn;
    logic [FT_W-1:0]       timer;

    // lanes are staggered by a fixed 37 px per index on top of the LFSR byte
    assign sum    = {2'b00, lfsr_lo} + 10'(37 * IDX);
    assign offset = 9'(sum % 10'(SPAWN_SPAN));
    assign spawn  = SPAWN_V + $signed(Y_W'(offset));

    assign press  = btn & ~btn_q;
    assign at_hit = (ytop >= HIT_V);
    assign hit    = press & at_hit;
    assign miss   = press & ~at_hit;
    assign lost   = (ytop >= LOSE_V);
    assign move   = run & ~freeze;

    // button history for rising-edge detection, tracked in every state
    always_ff @(posedge clk_vga) begin
        if (!game_rst_n) btn_q <= 1'b0;
        else             btn_q <= btn;
    end

    // lane position: load on start, respawn on hit, fall one px per tick
    always_ff @(posedge clk_vga) begin
        if (!game_rst_n) begin
            ytop <= SPAWN_V;
        end else if (load) begin
            ytop <= spawn;
        end else if (move) begin
            if (hit)       ytop <= spawn;
            else if (tick) ytop <= ytop + 1'b1;
        end
    end

    // hit flash: down-counter reloaded on every hit, flash drops at zero
    always_ff @(posedge clk_vga) begin
        if (!game_rst_n) begin
            flash <= 1'b0;
            timer <= '0;
        end else if (clear) begin
            flash <= 1'b0;
            timer <= '0;
        end else if (move && hit) begin
            flash <= 1'b1;
            timer <= FT_W'(FLASH_CYC - 1);
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end else begin
            flash <= 1'b0;
        end
    end

endmodule

// File: rtl/spider_lane_engine.sv
// Game engine top: run-state FSM, fall-step timer, LFSR, scoring and best score.
//
//  state   | meaning
//  IDLE    | after reset, lanes parked at SPAWN_MIN, waiting for start
//  RUN     | lanes falling, presses judged, score counting
//  OVER    | a lane was missed or lost, everything frozen until start
module spider_lane_engine
    import spider_pkg::*;
#(
    parameter int LANES      = 3,
    parameter int Y_W        = 13,
    parameter int HIT_Y      = HIT_Y_DEF,
    parameter int LOSE_Y     = LOSE_Y_DEF,
    parameter int SPAWN_MIN  = SPAWN_MIN_DEF,
    parameter int SPAWN_SPAN = SPAWN_SPAN_DEF,
    parameter int STEP_BASE  = 103600,
    parameter int FLASH_CYC  = 12000000,
    parameter int SCORE_W    = 14
) (
    input  logic                   clk_vga,
    input  logic                   game_rst_n,
    input  logic [LANES-1:0]       btn,
    input  logic [3:0]             level,
    input  logic                   start,
    output logic [LANES*Y_W-1:0]   ytop,
    output logic [LANES-1:0]       flash,
    output logic [SCORE_W-1:0]     score,
    output logic [SCORE_W-1:0]     best,
    output logic [1:0]             run_state,
    output logic                   over_voi,
    output logic [LANES-1:0]       hit_voi
);

    localparam int CNT_W = $clog2(15 * STEP_BASE);

    run_state_t       state_q, state_d;
    logic [15:0]      lfsr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_m1;
    logic [3:0]       level_eff;
    logic             run, tick, load, any_fail, clear;
    logic [LANES-1:0] hit_raw, miss_raw, lost_raw, hit_ok;
    logic [3:0]       hit_cnt;
    logic [SCORE_W:0] score_sum;

    assign run       = (state_q == ST_RUN);
    assign level_eff = (level == 4'd0) ? 4'd1 : level;
    assign period_m1 = CNT_W'(int'(level_eff) * STEP_BASE - 1);
    assign tick      = run && (cnt == period_m1);
    assign load      = start && (state_q != ST_RUN);
    assign any_fail  = run && (|(miss_raw | lost_raw));
    assign clear     = any_fail || (state_q == ST_OVER);
    assign hit_ok    = hit_raw & {LANES{run && !any_fail}};
    assign run_state = state_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        spider_lane #(
            .IDX(i), .Y_W(Y_W), .HIT_Y(HIT_Y), .LOSE_Y(LOSE_Y),
            .SPAWN_MIN(SPAWN_MIN), .SPAWN_SPAN(SPAWN_SPAN), .FLASH_CYC(FLASH_CYC)
        ) u_lane (
            .clk_vga(clk_vga), .game_rst_n(game_rst_n), .btn(btn[i]),
            .lfsr_lo(lfsr[7:0]), .tick(tick), .run(run), .freeze(any_fail),
            .load(load), .clear(clear), .ytop(ytop[i*Y_W +: Y_W]),
            .flash(flash[i]), .hit(hit_raw[i]), .miss(miss_raw[i]), .lost(lost_raw[i])
        );
    end

    // state register
    always_ff @(posedge clk_vga) begin
        if (!game_rst_n) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    // next-state: start leaves IDLE/OVER, any miss or lost ends the run
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_RUN;
            ST_RUN:  if (any_fail) state_d = ST_OVER;
            ST_OVER: if (start)    state_d = ST_RUN;
            default:               state_d = ST_IDLE;
        endcase
    end

    // spawn randomiser, free-running in every state
    always_ff @(posedge clk_vga) begin
        if (!game_rst_n) lfsr <= LFSR_SEED;
        else             lfsr <= lfsr_next(lfsr);
    end

    // fall-step timer, only counts while running
    always_ff @(posedge clk_vga) begin
        if (!game_rst_n || !run) cnt <= '0;
        else if (tick)           cnt <= '0;
        else                     cnt <= cnt + 1'b1;
    end

    // number of lanes hit this cycle
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < LANES; i++) hit_cnt = hit_cnt + 4'(hit_ok[i]);
    end

    assign score_sum = {1'b0, score} + (SCORE_W+1)'(hit_cnt);

    // saturating score, cleared on every new game
    always_ff @(posedge clk_vga) begin
        if (!game_rst_n)     score <= '0;
        else if (load)       score <= '0;
        else if (score_sum[SCORE_W]) score <= '1;
        else                 score <= score_sum[SCORE_W-1:0];
    end

    // best score captured while sitting in OVER
    always_ff @(posedge clk_vga) begin
        if (!game_rst_n)                          best <= '0;
        else if (state_q == ST_OVER && score > best) best <= score;
    end

    // registered strobes for the sound block
    always_ff @(posedge clk_vga) begin
        if (!game_rst_n) begin
            over_voi <= 1'b0;
            hit_voi  <= '0;
        end else begin
            over_voi <= any_fail;
            hit_voi  <= hit_ok;
        end
    end

endmodule

// File: tb/tb_spider_lane_engine.sv
// Directed bench for spider_lane_engine with a cycle-level reference model.
module tb_spider_lane_engine;

    localparam int LANES = 3, Y_W = 13, SCORE_W = 4, STEP_BASE = 4, FLASH_CYC = 8;
    localparam int HIT = 415, LOSE = 515, SMIN = -300, SSPAN = 235, SMAX = 15;

    logic clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    logic                  game_rst_n;
    logic [LANES-1:0]      btn;
    logic [3:0]            level;
    logic                  start;
    logic [LANES*Y_W-1:0]  ytop;
    logic [LANES-1:0]      flash;
    logic [SCORE_W-1:0]    score, best;
    logic [1:0]            run_state;
    logic                  over_voi;
    logic [LANES-1:0]      hit_voi;

    spider_lane_engine #(
        .LANES(LANES), .Y_W(Y_W), .STEP_BASE(STEP_BASE),
        .FLASH_CYC(FLASH_CYC), .SCORE_W(SCORE_W)
    ) dut (
        .clk_vga(clk_vga), .game_rst_n(game_rst_n), .btn(btn), .level(level),
        .start(start), .ytop(ytop), .flash(flash), .score(score), .best(best),
        .run_state(run_state), .over_voi(over_voi), .hit_voi(hit_voi)
    );

    int total = 0, bad = 0;

    // reference model state
    logic [15:0]      m_lfsr;
    int               m_state, m_cnt, m_score, m_best;
    int               m_y [LANES];
    int               m_fc[LANES];
    logic [LANES-1:0] m_btnq, m_hitv;
    logic             m_over;

    int               cyc, hits, multi, newp, ml, ya;
    logic [LANES-1:0] pm;

    function automatic logic signed [31:0] lane_y(input int i);
        return $signed(ytop[i*Y_W +: Y_W]);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [LANES-1:0] fe;
        for (int i = 0; i < LANES; i++) fe[i] = (m_fc[i] > 0);
        chk({tag, ":state"}, run_state, m_state);
        for (int i = 0; i < LANES; i++) chk({tag, ":ytop"}, lane_y(i), m_y[i]);
        chk({tag, ":flash"}, flash, fe);
        chk({tag, ":score"}, score, m_score);
        chk({tag, ":best"}, best, m_best);
        chk({tag, ":hit_voi"}, hit_voi, m_hitv);
        chk({tag, ":over_voi"}, over_voi, m_over);
    endtask

    // advance one clock; the model computes the post-edge state from pre-edge inputs
    task automatic step();
        logic [LANES-1:0] press, hitm, nbtnq, nhitv;
        int sp[LANES], ny[LANES], nfc[LANES];
        int nstate, ncnt, nscore, nbest, lv;
        bit fail, tk, nover;
        logic [15:0] nl;
        if (!game_rst_n) begin
            nstate = 0; ncnt = 0; nscore = 0; nbest = 0; nhitv = '0; nover = 0;
            nl = 16'hACE1; nbtnq = '0;
            for (int i = 0; i < LANES; i++) begin ny[i] = SMIN; nfc[i] = 0; end
        end else begin
            press = btn & ~m_btnq;
            nbtnq = btn;
            lv = (level == 0) ? 1 : int'(level);
            for (int i = 0; i < LANES; i++) begin
                sp[i]  = SMIN + ((int'(m_lfsr[7:0]) + 37 * i) % SSPAN);
                ny[i]  = m_y[i];
                nfc[i] = (m_fc[i] > 0) ? m_fc[i] - 1 : 0;
            end
            nstate = m_state; nscore = m_score; nbest = m_best;
            nhitv = '0; nover = 0; ncnt = 0; fail = 0; hitm = '0;
            tk = (m_state == 1) && (m_cnt == lv * STEP_BASE - 1);
            if (m_state == 1) begin
                for (int i = 0; i < LANES; i++) begin
                    if (press[i] && m_y[i] < HIT) fail = 1;
                    if (m_y[i] >= LOSE) fail = 1;
                    if (press[i] && m_y[i] >= HIT) hitm[i] = 1'b1;
                end
                ncnt = tk ? 0 : m_cnt + 1;
                if (fail) begin
                    nstate = 2; nover = 1;
                    for (int i = 0; i < LANES; i++) nfc[i] = 0;
                end else begin
                    for (int i = 0; i < LANES; i++) begin
                        if (hitm[i]) begin ny[i] = sp[i]; nfc[i] = FLASH_CYC; end
                        else if (tk) ny[i] = m_y[i] + 1;
                    end
                    nhitv  = hitm;
                    nscore = m_score + $countones(hitm);
                    if (nscore > SMAX) nscore = SMAX;
                end
            end else begin
                if (m_state == 2 && m_score > m_best) nbest = m_score;
                if (start) begin
                    nstate = 1; nscore = 0;
                    for (int i = 0; i < LANES; i++) ny[i] = sp[i];
                end
            end
            nl = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
        @(posedge clk_vga);
        #1;
        m_state = nstate; m_cnt = ncnt; m_score = nscore; m_best = nbest;
        m_hitv = nhitv; m_over = nover; m_lfsr = nl; m_btnq = nbtnq;
        for (int i = 0; i < LANES; i++) begin m_y[i] = ny[i]; m_fc[i] = nfc[i]; end
    endtask

    initial begin
        game_rst_n = 1'b0; btn = '0; level = 4'd1; start = 1'b0;
        step(); step();
        check_all("reset");
        chk("reset_state", run_state, 0);
        for (int i = 0; i < LANES; i++) chk("reset_ytop", lane_y(i), SMIN);

        game_rst_n = 1'b1;
        repeat (3) begin step(); check_all("idle"); end

        start = 1'b1; step(); start = 1'b0;
        chk("start_state", run_state, 1);
        chk("start_score", score, 0);
        for (int i = 0; i < LANES; i++) begin
            chk("spawn_lo", lane_y(i) >= -300, 1);
            chk("spawn_hi", lane_y(i) <= -66, 1);
        end
        check_all("start");
        repeat (12) begin step(); check_all("fall"); end
        ya = m_y[0];
        repeat (4) step();
        chk("fall_rate", lane_y(0), ya + 1);

        // play: hold lanes in the window and press them together just before loss
        cyc = 0; hits = 0; multi = 0;
        while (!(hits >= 18 && multi != 0 && btn == '0) && cyc < 60000) begin
            newp = 0;
            if (btn != '0) btn = '0;
            else begin
                pm = '0; ml = 0;
                for (int i = 0; i < LANES; i++) begin
                    if (m_y[i] >= LOSE - 3) ml = 1;
                    if (m_y[i] >= HIT) pm[i] = 1'b1;
                end
                if (ml != 0) begin btn = pm; newp = 1; end
            end
            step(); cyc++;
            check_all("play");
            if (newp != 0) begin
                hits += $countones(btn);
                if ($countones(btn) >= 2) multi = 1;
                chk("hit_strobe", hit_voi, btn);
                chk("hit_flash", flash & btn, btn);
                chk("hit_score", score, (hits > SMAX) ? SMAX : hits);
            end
        end
        chk("play_budget", cyc < 60000, 1);
        chk("score_saturated", score, SMAX);

        // miss: press the highest lane, which is above the hit window
        ml = 0;
        for (int i = 1; i < LANES; i++) if (m_y[i] < m_y[ml]) ml = i;
        btn = LANES'(1) << ml;
        step(); btn = '0;
        chk("miss_state", run_state, 2);
        chk("miss_over_voi", over_voi, 1);
        chk("miss_flash", flash, 0);
        check_all("miss");
        step();
        chk("miss_over_once", over_voi, 0);
        chk("miss_best", best, SMAX);
        check_all("over");
        btn = '1; step(); btn = '0; step();
        chk("over_ignores_press", run_state, 2);
        repeat (4) begin step(); check_all("over_frozen"); end

        // restart, then let a lane fall out
        start = 1'b1; step(); start = 1'b0;
        chk("restart_state", run_state, 1);
        chk("restart_score", score, 0);
        chk("restart_best", best, SMAX);
        check_all("restart");
        cyc = 0;
        while (m_state == 1 && cyc < 5000) begin step(); cyc++; check_all("lost_run"); end
        chk("lost_budget", cyc < 5000, 1);
        chk("lost_state", run_state, 2);
        chk("lost_over_voi", over_voi, 1);
        step();
        chk("lost_best_kept", best, SMAX);

        // slower level, then reset in the middle of a run
        level = 4'd2;
        start = 1'b1; step(); start = 1'b0;
        repeat (20) begin step(); check_all("level2"); end
        game_rst_n = 1'b0; step(); game_rst_n = 1'b1;
        chk("rst_state", run_state, 0);
        chk("rst_best", best, 0);
        chk("rst_score", score, 0);
        for (int i = 0; i < LANES; i++) chk("rst_ytop", lane_y(i), SMIN);
        check_all("rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
